// File: rtl/hci_bank_starvation_arbiter.sv
// hci_bank_starvation_arbiter
//
// Per-bank arbiter in front of one TCDM SRAM bank. It shares the bank between
// N_REQ log-interconnect (LIC) requesters and one HWPE shallow-branch port.
//
// Arbitration policy:
//   - Two classes, high and low. cfg_invert_prio_i picks which side is high.
//   - A starvation guard counts how many cycles the low class has been stalled.
//     Once that count reaches cfg_max_stall_i, a single BOOST cycle hands the
//     bank to the low class.
//   - Round-robin is used inside the LIC class.
//
// The 1-cycle-latency SRAM read response is routed back to whichever source
// was granted in the previous cycle.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   clear_i            synchronous clear of all internal state
//   cfg_invert_prio_i  0: LIC high / HWPE low, 1: HWPE high / LIC low
//   cfg_max_stall_i    stall cycles tolerated by the low class, 0 = guard off
//   lic_req_i/gnt_o    LIC request and same-cycle one-hot grant
//   hwpe_req_i/gnt_o   HWPE request and same-cycle grant
//   mem_req_o          bank request (any grant)
//   mem_sel_o          granted source index, N_REQ means HWPE
//   lic_rvalid_o       per-requester response valid, one cycle after grant
//   hwpe_rvalid_o      HWPE response valid, one cycle after grant
//   starve_evt_o       pulse on every boost grant
module hci_bank_starvation_arbiter #(
  parameter int unsigned N_REQ   = 8,
  parameter int unsigned STALL_W = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       cfg_invert_prio_i,
  input  logic [STALL_W-1:0]         cfg_max_stall_i,
  input  logic [N_REQ-1:0]           lic_req_i,
  output logic [N_REQ-1:0]           lic_gnt_o,
  input  logic                       hwpe_req_i,
  output logic                       hwpe_gnt_o,
  output logic                       mem_req_o,
  output logic [$clog2(N_REQ+1)-1:0] mem_sel_o,
  output logic [N_REQ-1:0]           lic_rvalid_o,
  output logic                       hwpe_rvalid_o,
  output logic                       starve_evt_o
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned SEL_W = $clog2(N_REQ+1);

  typedef enum logic {
    ST_NORMAL,
    ST_BOOST
  } state_e;

  state_e             state_q, state_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               invert_q;
  logic               resp_valid_q;
  logic [SEL_W-1:0]   resp_sel_q;

  logic               lic_any;
  logic               low_req, high_req;
  logic               grant_low, grant_high;
  logic               grant_lic, grant_hwpe;
  logic               lic_found;
  logic [PTR_W-1:0]   lic_idx;
  logic [PTR_W:0]     cand;
  logic [STALL_W:0]   stall_plus;
  logic               stall_inc;

  // Round-robin search: pick the first requesting LIC index at or after
  // rr_ptr, wrapping around. cand is one bit wider so that rr_ptr + i never
  // overflows before the wrap-around subtraction.
  always_comb begin
    lic_found = 1'b0;
    lic_idx   = '0;
    cand      = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(N_REQ)) begin
        cand = cand - (PTR_W+1)'(N_REQ);
      end
      if (!lic_found && lic_req_i[cand[PTR_W-1:0]]) begin
        lic_found = 1'b1;
        lic_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Class selection. The live cfg_invert_prio_i value is used here, so a
  // priority flip takes effect in the same cycle it is applied. In BOOST the
  // low class wins if it is requesting; otherwise the high class is served
  // normally.
  always_comb begin
    lic_any    = |lic_req_i;
    low_req    = cfg_invert_prio_i ? lic_any : hwpe_req_i;
    high_req   = cfg_invert_prio_i ? hwpe_req_i : lic_any;
    grant_low  = low_req && ((state_q == ST_BOOST) || !high_req);
    grant_high = high_req && !grant_low;
    grant_lic  = cfg_invert_prio_i ? grant_low : grant_high;
    grant_hwpe = cfg_invert_prio_i ? grant_high : grant_low;
  end

  // Grant and bank-select outputs.
  always_comb begin
    lic_gnt_o    = grant_lic ? (N_REQ'(1) << lic_idx) : '0;
    hwpe_gnt_o   = grant_hwpe;
    mem_req_o    = grant_lic | grant_hwpe;
    starve_evt_o = (state_q == ST_BOOST) && grant_low;
    mem_sel_o    = '0;
    if (grant_hwpe) begin
      mem_sel_o = SEL_W'(N_REQ);
    end else if (grant_lic) begin
      mem_sel_o = SEL_W'(lic_idx);
    end
  end

  // Next-state logic for the starvation FSM, the stall counter and the
  // round-robin pointer.
  //
  // BOOST lasts exactly one cycle: either the low class takes its grant, or
  // it has dropped its request. In both cases we fall back to NORMAL.
  //
  // A flip of the priority configuration overrides everything else and
  // restarts the guard from scratch.
  always_comb begin
    state_d    = state_q;
    stall_d    = stall_q;
    rr_ptr_d   = rr_ptr_q;
    stall_inc  = low_req && grant_high;
    stall_plus = {1'b0, stall_q} + (STALL_W+1)'(1);

    if (stall_inc) begin
      if (stall_q != '1) begin
        stall_d = stall_plus[STALL_W-1:0];
      end
    end else begin
      stall_d = '0;
    end

    case (state_q)
      ST_NORMAL: begin
        if (stall_inc && (cfg_max_stall_i != '0) &&
            (stall_plus >= {1'b0, cfg_max_stall_i})) begin
          state_d = ST_BOOST;
        end
      end
      ST_BOOST: begin
        state_d = ST_NORMAL;
        stall_d = '0;
      end
      default: begin
        state_d = ST_NORMAL;
      end
    endcase

    if (cfg_invert_prio_i != invert_q) begin
      state_d = ST_NORMAL;
      stall_d = '0;
    end

    if (grant_lic) begin
      if (lic_idx == PTR_W'(N_REQ-1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = lic_idx + PTR_W'(1);
      end
    end
  end

  // State registers. Reset and clear also drop any outstanding response, so
  // no rvalid ever appears for a grant issued before them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_NORMAL;
      stall_q      <= '0;
      rr_ptr_q     <= '0;
      invert_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_sel_q   <= '0;
    end else if (clear_i) begin
      state_q      <= ST_NORMAL;
      stall_q      <= '0;
      rr_ptr_q     <= '0;
      invert_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_sel_q   <= '0;
    end else begin
      state_q      <= state_d;
      stall_q      <= stall_d;
      rr_ptr_q     <= rr_ptr_d;
      invert_q     <= cfg_invert_prio_i;
      resp_valid_q <= mem_req_o;
      resp_sel_q   <= mem_sel_o;
    end
  end

  // Response routing: decode the registered select back to per-source valids.
  always_comb begin
    lic_rvalid_o = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      lic_rvalid_o[k] = resp_valid_q && (resp_sel_q == SEL_W'(k));
    end
    hwpe_rvalid_o = resp_valid_q && (resp_sel_q == SEL_W'(N_REQ));
  end

endmodule

// File: tb/tb_hci_bank_starvation_arbiter.sv
// tb_hci_bank_starvation_arbiter
//
// Directed bench for hci_bank_starvation_arbiter (N_REQ=8, STALL_W=8).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling
// edge. Every expected value below is worked out by hand from the arbitration
// rules.
module tb_hci_bank_starvation_arbiter;

  logic       clk_i;
  logic       rst_ni;
  logic       clear_i;
  logic       cfg_invert_prio_i;
  logic [7:0] cfg_max_stall_i;
  logic [7:0] lic_req_i;
  logic [7:0] lic_gnt_o;
  logic       hwpe_req_i;
  logic       hwpe_gnt_o;
  logic       mem_req_o;
  logic [3:0] mem_sel_o;
  logic [7:0] lic_rvalid_o;
  logic       hwpe_rvalid_o;
  logic       starve_evt_o;

  int check_count;
  int error_count;

  hci_bank_starvation_arbiter #(
    .N_REQ   (8),
    .STALL_W (8)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .clear_i           (clear_i),
    .cfg_invert_prio_i (cfg_invert_prio_i),
    .cfg_max_stall_i   (cfg_max_stall_i),
    .lic_req_i         (lic_req_i),
    .lic_gnt_o         (lic_gnt_o),
    .hwpe_req_i        (hwpe_req_i),
    .hwpe_gnt_o        (hwpe_gnt_o),
    .mem_req_o         (mem_req_o),
    .mem_sel_o         (mem_sel_o),
    .lic_rvalid_o      (lic_rvalid_o),
    .hwpe_rvalid_o     (hwpe_rvalid_o),
    .starve_evt_o      (starve_evt_o)
  );

  // 10ns clock
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Compare one observed value against its expected value and count it.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then wait for the
  // falling edge where outputs are sampled.
  task automatic applyStimulus(input logic [7:0] lic, input logic hwpe, input logic inv,
                               input logic [7:0] max_stall, input logic clr);
    @(posedge clk_i);
    #1;
    lic_req_i         = lic;
    hwpe_req_i        = hwpe;
    cfg_invert_prio_i = inv;
    cfg_max_stall_i   = max_stall;
    clear_i           = clr;
    @(negedge clk_i);
  endtask

  // Main sequence
  initial begin
    int         hwpe_hits;
    int         starve_hits;
    int         lic_hits;
    logic [7:0] exp_gnt;
    logic [7:0] prev_gnt;
    logic       hwpe_vec [8];
    logic       boost_vec [8];
    logic       clr_vec [8];

    check_count       = 0;
    error_count       = 0;
    rst_ni            = 1'b0;
    clear_i           = 1'b0;
    cfg_invert_prio_i = 1'b0;
    cfg_max_stall_i   = 8'd0;
    lic_req_i         = 8'hFF;
    hwpe_req_i        = 1'b1;

    // 1: reset with requests active
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_lic_rvalid", 32'(lic_rvalid_o), 32'h0);
    checkOutput("rst_hwpe_rvalid", 32'(hwpe_rvalid_o), 32'h0);
    checkOutput("rst_starve", 32'(starve_evt_o), 32'h0);
    lic_req_i  = 8'h00;
    hwpe_req_i = 1'b0;
    rst_ni     = 1'b1;

    applyStimulus(8'h01, 1'b0, 1'b0, 8'd0, 1'b0);
    checkOutput("t1_gnt", 32'(lic_gnt_o), 32'h01);
    checkOutput("t1_memreq", 32'(mem_req_o), 32'h1);
    checkOutput("t1_sel", 32'(mem_sel_o), 32'h0);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'd0, 1'b0);
    checkOutput("t1_rvalid", 32'(lic_rvalid_o), 32'h01);
    checkOutput("idle_gnt", 32'(lic_gnt_o), 32'h00);
    checkOutput("idle_memreq", 32'(mem_req_o), 32'h0);
    checkOutput("idle_sel", 32'(mem_sel_o), 32'h0);

    // rr_ptr is 1 now, so a request from index 2 is the first hit
    applyStimulus(8'h04, 1'b0, 1'b0, 8'd0, 1'b0);
    checkOutput("t1b_gnt", 32'(lic_gnt_o), 32'h04);
    checkOutput("t1b_sel", 32'(mem_sel_o), 32'h2);
    // reset right after the grant edge drops the pending response
    @(posedge clk_i);
    #1;
    rst_ni    = 1'b0;
    lic_req_i = 8'h00;
    @(negedge clk_i);
    checkOutput("rst_mid_rvalid", 32'(lic_rvalid_o), 32'h0);
    rst_ni = 1'b1;

    // 2: round robin with all LIC requesting
    prev_gnt = 8'h00;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(8'hFF, 1'b0, 1'b0, 8'd0, 1'b0);
      exp_gnt = 8'h01 << (i % 8);
      checkOutput($sformatf("rr_gnt_%0d", i), 32'(lic_gnt_o), 32'(exp_gnt));
      checkOutput($sformatf("rr_sel_%0d", i), 32'(mem_sel_o), 32'(i % 8));
      checkOutput($sformatf("rr_rvalid_%0d", i), 32'(lic_rvalid_o), 32'(prev_gnt));
      prev_gnt = exp_gnt;
    end
    applyStimulus(8'h00, 1'b0, 1'b0, 8'd0, 1'b0);
    checkOutput("rr_last_rvalid", 32'(lic_rvalid_o), 32'h01);

    // 3: starvation guard, max_stall = 3
    for (int s = 0; s < 8; s++) begin
      applyStimulus(8'h01, 1'b1, 1'b0, 8'd3, 1'b0);
      checkOutput($sformatf("sv_hwpe_%0d", s), 32'(hwpe_gnt_o), 32'((s % 4) == 3));
      checkOutput($sformatf("sv_lic_%0d", s), 32'(lic_gnt_o), ((s % 4) == 3) ? 32'h0 : 32'h1);
      checkOutput($sformatf("sv_starve_%0d", s), 32'(starve_evt_o), 32'((s % 4) == 3));
      checkOutput($sformatf("sv_sel_%0d", s), 32'(mem_sel_o), ((s % 4) == 3) ? 32'h8 : 32'h0);
      checkOutput($sformatf("sv_hrvalid_%0d", s), 32'(hwpe_rvalid_o),
                  32'(((s % 4) == 0) && (s > 0)));
    end

    // 4: guard disabled, 100 cycles of the same contention
    hwpe_hits   = 0;
    starve_hits = 0;
    lic_hits    = 0;
    for (int s = 0; s < 100; s++) begin
      applyStimulus(8'h01, 1'b1, 1'b0, 8'd0, 1'b0);
      if (hwpe_gnt_o)           hwpe_hits++;
      if (starve_evt_o)         starve_hits++;
      if (lic_gnt_o == 8'h01)   lic_hits++;
    end
    checkOutput("off_hwpe_hits", 32'(hwpe_hits), 32'd0);
    checkOutput("off_starve_hits", 32'(starve_hits), 32'd0);
    checkOutput("off_lic_hits", 32'(lic_hits), 32'd100);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'd0, 1'b0);

    // 5: inverted priority, then flip back with the stall count at 2
    for (int s = 0; s < 3; s++) begin
      applyStimulus(8'h01, 1'b1, 1'b1, 8'd3, 1'b0);
      checkOutput($sformatf("inv_hwpe_%0d", s), 32'(hwpe_gnt_o), 32'h1);
      checkOutput($sformatf("inv_lic_%0d", s), 32'(lic_gnt_o), 32'h0);
      checkOutput($sformatf("inv_starve_%0d", s), 32'(starve_evt_o), 32'h0);
    end
    for (int s = 0; s < 5; s++) begin
      applyStimulus(8'h01, 1'b1, 1'b0, 8'd3, 1'b0);
      checkOutput($sformatf("flip_hwpe_%0d", s), 32'(hwpe_gnt_o), 32'(s == 4));
      checkOutput($sformatf("flip_starve_%0d", s), 32'(starve_evt_o), 32'(s == 4));
    end

    // 6: low class drops its request while in BOOST
    hwpe_vec  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    boost_vec = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int s = 0; s < 8; s++) begin
      applyStimulus(8'h01, hwpe_vec[s], 1'b0, 8'd3, 1'b0);
      checkOutput($sformatf("drop_hwpe_%0d", s), 32'(hwpe_gnt_o), 32'(boost_vec[s]));
      checkOutput($sformatf("drop_lic_%0d", s), 32'(lic_gnt_o), boost_vec[s] ? 32'h0 : 32'h1);
      checkOutput($sformatf("drop_starve_%0d", s), 32'(starve_evt_o), 32'(boost_vec[s]));
    end

    // 7: synchronous clear with the stall count at 2
    clr_vec   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    boost_vec = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int s = 0; s < 7; s++) begin
      applyStimulus(8'h01, 1'b1, 1'b0, 8'd3, clr_vec[s]);
      checkOutput($sformatf("clr_hwpe_%0d", s), 32'(hwpe_gnt_o), 32'(boost_vec[s]));
      checkOutput($sformatf("clr_starve_%0d", s), 32'(starve_evt_o), 32'(boost_vec[s]));
      checkOutput($sformatf("clr_rvalid_%0d", s), 32'(lic_rvalid_o),
                  ((s == 3) || (s == 0)) ? 32'h0 : 32'h1);
    end

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
